cg_enable_ctrl: RTL
===================

Name: cg_enable_ctrl

Overview:
- Upstream enable generator for the clock-gating cell.
- Watches the data bus feeding the gated capture registers, plus explicit requests.
- Drives the gating cell's enable input `in` so the gated clock runs only while data is changing or requested, and for a programmable hold-off window afterwards.
- Also keeps a saturating count of gated (clock-off) cycles for power reporting.

Parameters:
- WIDTH, 2, width of monitored data bus (bit i feeds downstream capture register q_i).
- IDLE_CYCLES, 4, consecutive inactive edges before the enable is dropped (>=1).
- MIN_ON, 2, minimum edges the enable stays high after a wake from OFF (>=1).
- CNT_W, 16, width of the gated-cycle counter.

Ports:
- clk  input  1  free-running (ungated) clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- data_in  input  WIDTH  data bus presented to the downstream gated registers.
- req  input  1  explicit activity request, level-sensitive.
- force_on  input  1  keep clock running unconditionally while high.
- cnt_clr  input  1  synchronous clear of gated_cnt.
- cg_en  output  1  registered enable to the clock-gating cell input `in`.
- wake_pulse  output  1  one-cycle pulse on the OFF->ON transition.
- state  output  2  current FSM state (ON=2'b00, COUNTDOWN=2'b01, OFF=2'b10).
- gated_cnt  output  CNT_W  number of edges spent in OFF, saturating.

Behaviour:
- Reset is synchronous, active-low, one clock. Sampled at a posedge with rst_n=0:
  - state=ON, cg_en=1, wake_pulse=0, gated_cnt=0
  - data_last=0, idle_cnt=0, min_cnt=MIN_ON-1
  - Reset mid-operation (including from OFF) returns to exactly these values at that edge; no wake_pulse.
- data_last: registered copy of data_in, updated every clk edge regardless of state.
- act = req | force_on | (data_in != data_last), evaluated combinationally in the cycle before each edge.
- idle_cnt: cleared on any edge with act=1; otherwise increments, saturating at IDLE_CYCLES-1.
- min_cnt: loaded with MIN_ON-1 on entry to ON from OFF; decrements to 0 each edge while not OFF.
- FSM transitions, evaluated at each edge:
  - ON:
    - act=1 -> ON.
    - act=0 and IDLE_CYCLES>1 -> COUNTDOWN.
    - act=0, IDLE_CYCLES==1 and min_cnt==0 -> OFF.
  - COUNTDOWN:
    - act=1 -> ON.
    - act=0, idle_cnt==IDLE_CYCLES-1 (pre-edge value) and min_cnt==0 -> OFF.
    - otherwise stay.
  - OFF:
    - act=1 -> ON; wake_pulse=1 for exactly that next cycle; min_cnt reloaded.
    - otherwise stay.
- Net timing:
  - Last activity sampled at edge t -> cg_en low after edge t+max(IDLE_CYCLES, MIN_ON remaining).
  - Activity sampled at edge w in OFF -> cg_en high after edge w (one-cycle wake latency); the gating cell adds its own capture delay downstream.
- Outputs:
  - cg_en registered, equal to (state != OFF). No combinational path from any input to cg_en.
  - wake_pulse registered.
- force_on:
  - Overrides everything; state forced to ON while high.
  - On release, normal countdown starts from idle_cnt=0.
- gated_cnt:
  - Increments at each edge where the pre-edge state==OFF.
  - Holds at all-ones (saturates).
  - cnt_clr=1 clears it to 0 at that edge and has priority over increment.
- Simultaneous events:
  - A data change and req in the same cycle count as one activity.
  - act=1 on the very edge the countdown would expire -> stay enabled (activity wins).
- Data change while OFF: data_last still tracks it, so the wake is triggered by the first differing sample. Since cg_en rises one edge after the change, the source must hold data_in stable for at least 2 edges after a change while OFF.

Test Plan:
- Reset, then data_in held at 0, req=0, IDLE_CYCLES=4, MIN_ON=2:
  - state ON->COUNTDOWN at edge 1.
  - cg_en=1 through edge 3; OFF and cg_en=0 after edge 4.
  - gated_cnt=3 after edge 7.
- In OFF, data_in 2'b00->2'b10:
  - cg_en=1 and wake_pulse=1 for one cycle after the first edge sampling 2'b10.
  - state=ON; with data then static, cg_en drops 4 edges later.
- In COUNTDOWN with idle_cnt=3, req=1 at the expiry edge -> state ON, cg_en stays 1, idle_cnt=0, no wake_pulse.
- force_on=1 for 10 cycles with static data -> cg_en=1 throughout, gated_cnt unchanged. Release -> OFF exactly 4 edges later.
- gated_cnt with CNT_W=4, held in OFF for 20 edges -> saturates at 15. cnt_clr=1 in the same cycle as an OFF edge -> gated_cnt=0.
- rst_n=0 for one edge while OFF with gated_cnt=9 -> next cycle state=ON, cg_en=1, gated_cnt=0, wake_pulse=0.

Source files
------------

// File: rtl/cg_enable_ctrl.sv
// rtl/cg_enable_ctrl.sv - activity-driven enable generator for a clock-gating cell
//
// Purpose:
//   Watches the data bus feeding the gated capture registers plus explicit
//   requests, and produces a registered enable for the clock-gating cell.
//   The gated clock runs while data changes or is requested, then for an
//   IDLE_CYCLES hold-off window (never shorter than MIN_ON edges after a wake).
//   It also keeps a saturating count of clock-off edges for power reporting.
//
// Ports:
//   clk        in   free-running clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   data_in    in   [WIDTH] bus presented to the downstream gated registers
//   req        in   level-sensitive explicit activity request
//   force_on   in   keep the clock running unconditionally while high
//   cnt_clr    in   synchronous clear of gated_cnt (wins over increment)
//   cg_en      out  registered enable to the gating cell, high unless OFF
//   wake_pulse out  registered one-cycle pulse on the OFF->ON transition
//   state      out  [2] FSM state: ON=00, COUNTDOWN=01, OFF=10
//   gated_cnt  out  [CNT_W] saturating count of edges spent in OFF

module cg_enable_ctrl #(
  parameter int WIDTH       = 2,
  parameter int IDLE_CYCLES = 4,
  parameter int MIN_ON      = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             req,
  input  logic             force_on,
  input  logic             cnt_clr,
  output logic             cg_en,
  output logic             wake_pulse,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] gated_cnt
);

  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int MW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
  localparam logic [MW-1:0] MIN_LOAD = MW'(MIN_ON - 1);

  typedef enum logic [1:0] {
    ST_ON  = 2'b00,
    ST_CD  = 2'b01,
    ST_OFF = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_last_q, data_last_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [MW-1:0]    min_cnt_q, min_cnt_d;
  logic             cg_en_q, cg_en_d;
  logic             wake_pulse_q, wake_pulse_d;
  logic [CNT_W-1:0] gated_cnt_q, gated_cnt_d;
  logic             act;

  always_comb begin
    act          = req | force_on | (data_in != data_last_q);

    state_d      = state_q;
    data_last_d  = data_in;
    idle_cnt_d   = idle_cnt_q;
    min_cnt_d    = min_cnt_q;
    wake_pulse_d = 1'b0;
    gated_cnt_d  = gated_cnt_q;

    if (act) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end

    // min_cnt only runs while the clock is on; it is re-armed on every wake.
    if (state_q == ST_OFF) begin
      if (act) begin
        min_cnt_d = MIN_LOAD;
      end
    end else if (min_cnt_q != '0) begin
      min_cnt_d = min_cnt_q - MW'(1);
    end

    // force_on folds into act, so it always lands in (or stays in) ON.
    case (state_q)
      ST_ON: begin
        if (!act) begin
          if (IDLE_CYCLES > 1) begin
            state_d = ST_CD;
          end else if (min_cnt_q == '0) begin
            state_d = ST_OFF;
          end
        end
      end
      ST_CD: begin
        if (act) begin
          state_d = ST_ON;
        end else if ((idle_cnt_q == IDLE_MAX) && (min_cnt_q == '0)) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        if (act) begin
          state_d      = ST_ON;
          wake_pulse_d = 1'b1;
        end
      end
      default: state_d = ST_ON;
    endcase

    if (cnt_clr) begin
      gated_cnt_d = '0;
    end else if ((state_q == ST_OFF) && (gated_cnt_q != '1)) begin
      gated_cnt_d = gated_cnt_q + CNT_W'(1);
    end

    cg_en_d = (state_d != ST_OFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ON;
      data_last_q  <= '0;
      idle_cnt_q   <= '0;
      min_cnt_q    <= MIN_LOAD;
      cg_en_q      <= 1'b1;
      wake_pulse_q <= 1'b0;
      gated_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_last_q  <= data_last_d;
      idle_cnt_q   <= idle_cnt_d;
      min_cnt_q    <= min_cnt_d;
      cg_en_q      <= cg_en_d;
      wake_pulse_q <= wake_pulse_d;
      gated_cnt_q  <= gated_cnt_d;
    end
  end

  assign cg_en      = cg_en_q;
  assign wake_pulse = wake_pulse_q;
  assign state      = state_q;
  assign gated_cnt  = gated_cnt_q;

endmodule
